sram_fifo_ctrl: RTL
===================

# sram_fifo_ctrl

Synchronous FIFO controller that wraps one two-port register-file macro: write port B (AB/DB/CENB) and read port A (AA/CENA/QA), each with an active-low enable and one-cycle read latency. It turns the raw SRAM into a valid/ready stream buffer for the JPEG datapath, for example between the DCT/quantiser and the entropy coder. A 2-entry output buffer hides the read latency and sustains one transfer per cycle. The macro itself is instantiated outside this block; this block drives its ports.

## Interface
- DEPTH, 32, SRAM word count; power of two, ≥ 4.
- WIDTH, 64, data width in bits.
- AW, $clog2(DEPTH), SRAM address width (derived).
- CW, $clog2(DEPTH+3), width of the `count` output (derived).

Ports:
- clk  in  1  single clock for the block and both SRAM ports.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  upstream word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  head-of-FIFO word.
- count  out  CW  total words held: SRAM + read in flight + output buffer.
- ram_aa  out  AW  read address (drives AA).
- ram_cena  out  1  read enable, active-low (drives CENA).
- ram_qa  in  WIDTH  read data (from QA), valid the cycle after ram_cena=0.
- ram_ab  out  AW  write address (drives AB).
- ram_db  out  WIDTH  write data (drives DB).
- ram_cenb  out  1  write enable, active-low (drives CENB).

## Operation
- Push: when `in_valid & in_ready`, drive ram_cenb=0, ram_ab=wr_ptr, ram_db=in_data; then wr_ptr++ modulo DEPTH.
- The SRAM occupancy counter `sram_cnt` (0..DEPTH) is incremented on a push and decremented on a read issue.
- `in_ready` = `!rst & (sram_cnt != DEPTH)`. It is decoded from registers and does not depend on out_ready.
- Read issue: drive ram_cena=0, ram_aa=rd_ptr when `sram_cnt != 0 & (ob_cnt + inflight − pop) < 2`.
  - `pop` = `out_valid & out_ready`.
  - On issue, rd_ptr++ modulo DEPTH and set `inflight` for the next cycle.
- Write-to-read visibility: a word pushed at edge N may be read-issued in the cycle after edge N. No same-cycle bypass.
- The read and write addresses are never equal in the same cycle (read only when sram_cnt>0, write only when sram_cnt<DEPTH). No collision handling is needed.
- Output buffer: a 2-entry FIFO with `ob_cnt` 0..2.
  - When `inflight`=1, ram_qa is written into it at the next edge.
  - Head entry drives out_data; `out_valid` = `ob_cnt != 0`.
  - Simultaneous capture and pop: the head advances and the new word lands behind it, ob_cnt unchanged. Order is strictly preserved.
- Push and read issue in the same cycle: sram_cnt unchanged; both pointers advance.
- Pointer wrap: DEPTH−1 → 0 with no gap.
- Capacity is DEPTH+2 words. `count` = sram_cnt + inflight + ob_cnt.
- Idle: ram_cena=1 and ram_cenb=1. Address and data buses hold their last values (don't-care).

## Timing
- Reset (rst=1 at an edge): wr_ptr=rd_ptr=0, sram_cnt=0, inflight=0, ob_cnt=0.
- While rst=1, and after reset is released:
  - out_valid=0, count=0.
  - ram_cena=1, ram_cenb=1.
  - in_ready=0 while rst=1, 1 from the first cycle after rst falls.
- Reset mid-operation discards all contents. No SRAM access is issued in a cycle where rst=1.
- Latency on an empty FIFO:
  - Word accepted at edge N.
  - Read issued in cycle N..N+1.
  - Captured at edge N+2.
  - out_valid=1 after edge N+2.
- Throughput: with out_ready held at 1 and in_valid held at 1, exactly one word in and one word out per cycle at steady state.
- out_data and out_valid are stable while `out_valid & !out_ready`.
- Full: count=DEPTH+2, with in_ready=0 during the cycle sram_cnt=DEPTH.
  - A single pop frees one slot.
  - in_ready rises within 2 cycles after the pop edge, once the refill read issues.

## Test plan
- Reset: hold rst=1 for 3 cycles mid-stream with 10 words stored → after release, count=0, out_valid=0, ram_cena=ram_cenb=1, in_ready=1; previously stored words never appear.
- Single word on empty FIFO: push 0x0123456789ABCDEF at edge N → ram_cenb=0 with ram_ab=0 in that cycle; ram_cena=0 with ram_aa=0 in the next cycle; out_valid=1 with that data after edge N+2.
- Streaming: 100 sequential words, in_valid=out_ready=1 → output sequence identical; after the 2-cycle fill, one word per cycle with no bubbles.
- Fill to full with out_ready=0, DEPTH=32 → in_ready drops after 34 accepted words, count=34; pop one → in_ready=1 again within 2 cycles; the 35th word is accepted and later output in order.
- Wrap-around: push and pop 3×DEPTH random words with random in_valid/out_ready (≈50% each) → scoreboard matches exactly; ram_ab/ram_aa wrap 31→0; count never exceeds 34.
- Backpressure stability: out_ready=0 for 5 cycles while out_valid=1 → out_data unchanged across all 5 cycles; the next pop yields the following word, none lost or duplicated.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO around an external two-port register file.
// The write port (B) stores accepted words and the read port (A) prefetches
// them into a 2-entry output buffer. That buffer hides the one-cycle read
// latency, so one word can move in and one word out on every clock.
module sram_fifo_ctrl #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [AW-1:0]    ram_aa,
    output logic             ram_cena,
    input  logic [WIDTH-1:0] ram_qa,
    output logic [AW-1:0]    ram_ab,
    output logic [WIDTH-1:0] ram_db,
    output logic             ram_cenb
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Pointers and occupancy of the SRAM itself.
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      sram_cnt;

    // A read was issued in the previous cycle, so ram_qa is valid now.
    logic             inflight;

    // Output buffer: the head entry is presented downstream and the tail
    // entry queues behind it.
    logic [1:0]       ob_cnt;
    logic [WIDTH-1:0] ob_head;
    logic [WIDTH-1:0] ob_tail;

    logic             push;
    logic             pop;
    logic             rd_issue;
    logic [2:0]       ob_claim;
    logic [2:0]       ob_limit;

    // Handshakes and read-issue decision. A read may only be issued while
    // the words already owned by the output side (buffered plus in flight,
    // less the one leaving this cycle) leave room for it.
    always_comb begin
        in_ready  = !rst && (sram_cnt != FULL_CNT);
        push      = in_valid && in_ready;
        out_valid = !rst && (ob_cnt != 2'd0);
        pop       = out_valid && out_ready;
        ob_claim  = {1'b0, ob_cnt} + {2'b00, inflight};
        ob_limit  = 3'd2 + {2'b00, pop};
        rd_issue  = !rst && (sram_cnt != '0) && (ob_claim < ob_limit);
    end

    // SRAM port drive. Addresses and write data follow the pointers and the
    // input bus; they only matter while the matching enable is low.
    always_comb begin
        ram_cenb = !push;
        ram_ab   = wr_ptr;
        ram_db   = in_data;
        ram_cena = !rd_issue;
        ram_aa   = rd_ptr;
    end

    // Head of the FIFO and the total word count. Both read zero during reset.
    always_comb begin
        out_data = ob_head;
        if (rst) begin
            count = '0;
        end else begin
            count = CW'(sram_cnt) + CW'(inflight) + CW'(ob_cnt);
        end
    end

    // Control state: pointers, SRAM occupancy, read pipeline, buffer fill.
    // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
            ob_cnt   <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, rd_issue})
                2'b10:   sram_cnt <= sram_cnt + 1'b1;
                2'b01:   sram_cnt <= sram_cnt - 1'b1;
                default: sram_cnt <= sram_cnt;
            endcase
            inflight <= rd_issue;
            case ({inflight, pop})
                2'b10:   ob_cnt <= ob_cnt + 2'd1;
                2'b01:   ob_cnt <= ob_cnt - 2'd1;
                default: ob_cnt <= ob_cnt;
            endcase
        end
    end

    // Output buffer data. A returning read word lands in the first free
    // slot after any pop this cycle, which keeps the words in order.
    always_ff @(posedge clk) begin
        if (inflight) begin
            if (ob_cnt == 2'd0 || (ob_cnt == 2'd1 && pop)) begin
                ob_head <= ram_qa;
            end else if (ob_cnt == 2'd2 && pop) begin
                ob_head <= ob_tail;
                ob_tail <= ram_qa;
            end else begin
                ob_tail <= ram_qa;
            end
        end else if (pop) begin
            ob_head <= ob_tail;
        end
    end

endmodule
